stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Single-clock, parametrised MM:SS stopwatch core for the four-digit seven-segment board. It replaces the multi-clock divider/counter/display arrangement with clock enables derived from `clk`. It provides run, pause-toggle and per-field adjust modes, a configurable minute limit, and its own multiplexed display driver with adjust-field blinking. It sits directly under the board top, taking debounced, synchronised switch and button levels.

## Interface
- `TICK_DIV`, 100_000_000: `clk` cycles per count tick (1 Hz); must be ≥2.
- `ADJ_DIV`, 50_000_000: `clk` cycles per adjust increment (2 Hz); must be ≥2.
- `BLINK_DIV`, 25_000_000: `clk` cycles per blink-phase toggle; must be ≥2.
- `SCAN_DIV`, 100_000: `clk` cycles per display digit advance; must be ≥1.
- `MIN_MAX`, 99: highest minute value, 1..99.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high, clears all state.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; adjust field select, 0 = minutes, 1 = seconds.
- `pause`  in  1  level; each rising edge toggles the paused state.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits, registered.
- `seg`  out  8  segments, active-low, `{dp,g,f,e,d,c,b,a}`, registered.
- `an`  out  4  digit enables, active-low; bit0 = `sec_ones`, bit3 = `min_tens`; registered.
- `running`  out  1  `~paused & ~adj`.

## Operation
- **Count divider** runs 0..TICK_DIV-1 and ticks at TICK_DIV-1. It is held at 0 while `paused` or `adj`, so after a resume or adj exit the first tick is exactly TICK_DIV cycles later.
- **Tick while running:** seconds 59→00 carries into minutes. At MIN_MAX:59 the next tick gives 00:00.
- **Adjust divider** works the same way with ADJ_DIV and is held at 0 while `adj`=0.
- **Adjust tick:** increments the field selected by `sel` by 1 with no carry. Seconds wrap 59→00; minutes wrap MIN_MAX→00. The adjust tick is applied regardless of `paused`, and `paused` is kept unchanged.
- **Pause:** `pause` is registered once for edge detection. A rising edge toggles `paused`, including while `adj`=1.
- **Scan:** a scan counter advances the digit index 0→1→2→3→0 every SCAN_DIV cycles.
  - `an` is the one-hot-low of the index.
  - `seg[6:0]` is the decode of the indexed digit: 0..9 → 40,79,24,30,19,12,02,78,00,10 hex. Codes 10..15 → 7F (blank).
  - `seg[7]` is 0 only on index 2 (colon); otherwise 1.
- **Blink:** the blink phase toggles every BLINK_DIV cycles while `adj`=1 and is held 0 while `adj`=0. When the phase is 1 and the index points to the selected field (indices 2–3 for `sel`=0, 0–1 for `sel`=1), `an` = 4'b1111.

## Timing
- **Reset values:** all digits 0, `paused`=0, all dividers and the scan index 0, blink phase 0, `an`=4'b1110, `seg`=8'hC0, `running`=1.
- **Digit latency:** a digit change is visible at the clock edge where the divider equals DIV-1. With TICK_DIV=4, `sec_ones`=1 after the 4th rising edge following `rst` deassertion.
- **Display latency:** `seg`/`an` are registered from current state and trail digit changes by 1 cycle.
- **Pause edge with tick:** if a pause edge and a count tick fall in the same cycle, the tick uses the pre-toggle `paused` and is applied.
- **adj rising with tick:** if `adj` rises in the same cycle as a count tick, `adj` wins and there is no increment.
- **sel change mid-adjust:** the next adjust tick applies to the new field; the adjust divider is not reset.
- **`rst` mid-operation:** asynchronously forces all reset values within the same cycle.

## Test plan
All scenarios use TICK_DIV=4, ADJ_DIV=2, BLINK_DIV=3, SCAN_DIV=2, MIN_MAX=2.
- **Run and wrap:** hold `rst` 3 cycles, then run 4×180 cycles → digits step 00:00, 00:01 … 02:59, then return to 00:00 at cycle 720. `running`=1 throughout.
- **Pause:** pulse `pause` at cycle 5, hold 20 cycles, pulse again → digits frozen at 00:01 while paused. The next increment to 00:02 occurs exactly 4 cycles after the second rising edge registers.
- **Adjust:** set `adj`=1, `sel`=1 from 00:58 → seconds go 59, 00, 01 every 2 cycles, with minutes held at 00. Switch `sel`=0 → minutes go 01, 02, 00.
- **Blink and scan:** set `adj`=1, `sel`=0, digits 01:23 → `an` sequence 1110/1101/1011/0111 every 2 cycles with the matching `seg` codes 30,24,79(dp 0 → 79 hex w/ bit7=0),40. `an`=1111 on indices 2–3 during blink phase 1.
- **Simultaneous pause/tick:** assert the `pause` rising edge on the cycle a count tick lands → that increment still happens, then counting stops.
- **Async reset mid-count:** pulse `rst` mid-cycle at 01:37 → all digits are 0, `an`=1110 and `seg`=C0 before the next clock edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch core with run/pause/adjust modes and a multiplexed
// four-digit seven-segment driver; every rate is a clock enable derived from clk.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned ADJ_DIV   = 50_000_000,
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned MIN_MAX   = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adj,
    input  logic       sel,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       running
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(ADJ_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [3:0]    MAX_T      = 4'(MIN_MAX / 10);
    localparam logic [3:0]    MAX_O      = 4'(MIN_MAX % 10);

    typedef enum logic {
        ST_RUN,
        ST_PAUSED
    } state_t;

    state_t        state_q, state_d;
    logic          pause_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [AW-1:0] adj_cnt_q, adj_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          paused;
    logic          pause_edge;
    logic          count_tick;
    logic          adj_tick;
    logic          sec_wrap;
    logic [3:0]    sec_nt, sec_no, min_nt, min_no;
    logic [3:0]    cur_digit;
    logic          field_hit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign paused     = (state_q == ST_PAUSED);
    assign pause_edge = pause & ~pause_q;
    // adj is used raw so that adj rising on a tick cycle suppresses that tick
    assign count_tick = ~paused & ~adj & (tick_cnt_q == TICK_LAST);
    assign adj_tick   = adj & (adj_cnt_q == ADJ_LAST);
    assign running    = ~paused & ~adj;

    always_comb begin
        sec_wrap = (st_q == 4'd5) && (so_q == 4'd9);
        sec_nt   = st_q;
        sec_no   = so_q + 4'd1;
        if (so_q == 4'd9) begin
            sec_no = '0;
            sec_nt = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
        end
        min_nt = mt_q;
        min_no = mo_q + 4'd1;
        if (mt_q == MAX_T && mo_q == MAX_O) begin
            min_nt = '0;
            min_no = '0;
        end else if (mo_q == 4'd9) begin
            min_nt = mt_q + 4'd1;
            min_no = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        adj_cnt_d   = adj_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        mt_d        = mt_q;
        mo_d        = mo_q;
        st_d        = st_q;
        so_d        = so_q;

        if (pause_edge) begin
            state_d = paused ? ST_RUN : ST_PAUSED;
        end

        if (paused || adj || tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        if (!adj || adj_cnt_q == ADJ_LAST) begin
            adj_cnt_d = '0;
        end else begin
            adj_cnt_d = adj_cnt_q + 1'b1;
        end

        if (!adj) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        if (count_tick) begin
            st_d = sec_nt;
            so_d = sec_no;
            if (sec_wrap) begin
                mt_d = min_nt;
                mo_d = min_no;
            end
        end else if (adj_tick) begin
            if (sel) begin
                st_d = sec_nt;
                so_d = sec_no;
            end else begin
                mt_d = min_nt;
                mo_d = min_no;
            end
        end
    end

    // Display is built from the current registered state, so it trails digits by one cycle
    always_comb begin
        case (idx_q)
            2'd0:    cur_digit = so_q;
            2'd1:    cur_digit = st_q;
            2'd2:    cur_digit = mo_q;
            default: cur_digit = mt_q;
        endcase
        field_hit = sel ? ~idx_q[1] : idx_q[1];
        seg_d     = {(idx_q != 2'd2), seg7(cur_digit)};
        an_d      = ~(4'b0001 << idx_q);
        if (blink_q && field_hit) begin
            an_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pause_q     <= 1'b0;
            tick_cnt_q  <= '0;
            adj_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            mt_q        <= '0;
            mo_q        <= '0;
            st_q        <= '0;
            so_q        <= '0;
            seg_q       <= 8'hC0;
            an_q        <= 4'b1110;
        end else begin
            state_q     <= state_d;
            pause_q     <= pause;
            tick_cnt_q  <= tick_cnt_d;
            adj_cnt_q   <= adj_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            mt_q        <= mt_d;
            mo_q        <= mo_d;
            st_q        <= st_d;
            so_q        <= so_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small dividers; cycle numbers count
// rising edges after reset release.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       adj;
    logic       sel;
    logic       pause;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [7:0] seg;
    logic [3:0] an;
    logic       running;
    logic [15:0] digits;

    int unsigned checks;
    int unsigned failures;
    int unsigned cyc;

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .ADJ_DIV  (2),
        .BLINK_DIV(3),
        .SCAN_DIV (2),
        .MIN_MAX  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .adj     (adj),
        .sel     (sel),
        .pause   (pause),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .seg     (seg),
        .an      (an),
        .running (running)
    );

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after rising edge number c.
    task automatic to(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1; adj = 1'b0; sel = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits",  digits, 16'h0000);
        chk("rst_an",      {12'h000, an}, 16'h000E);
        chk("rst_seg",     {8'h00, seg}, 16'h00C0);
        chk("rst_running", {15'h0000, running}, 16'h0001);
        rst = 1'b0;

        to(3);   chk("tick_not_yet", digits, 16'h0000);
        to(4);   chk("first_tick", digits, 16'h0001);
                 chk("running_1", {15'h0000, running}, 16'h0001);
        to(240); chk("min_carry", digits, 16'h0100);
        to(716); chk("max_time", digits, 16'h0259);
        to(717); chk("scan_an_idx2", {12'h000, an}, 16'h000B);
                 chk("scan_seg_colon", {8'h00, seg}, 16'h0024);
        to(720); chk("wrap_to_zero", digits, 16'h0000);
                 chk("running_wrap", {15'h0000, running}, 16'h0001);

        to(725); pause = 1'b1;
        to(726); pause = 1'b0;
        to(746); chk("paused_frozen", digits, 16'h0001);
                 chk("paused_running", {15'h0000, running}, 16'h0000);
        pause = 1'b1;
        to(747); pause = 1'b0;
        to(750); chk("resume_3cyc", digits, 16'h0001);
        to(751); chk("resume_4cyc", digits, 16'h0002);
                 chk("resume_running", {15'h0000, running}, 16'h0001);

        to(754); pause = 1'b1;
        to(755); pause = 1'b0;
        chk("pause_tick_same", digits, 16'h0003);
        chk("pause_tick_run", {15'h0000, running}, 16'h0000);
        to(763); chk("pause_tick_hold", digits, 16'h0003);

        adj = 1'b1; sel = 1'b1;
        to(873); chk("adj_sec_58", digits, 16'h0058);
        to(875); chk("adj_sec_59", digits, 16'h0059);
        to(876); chk("adj_sec_hold", digits, 16'h0059);
        to(877); chk("adj_sec_wrap", digits, 16'h0000);
        to(879); chk("adj_sec_01", digits, 16'h0001);
        sel = 1'b0;
        to(881); chk("adj_min_01", digits, 16'h0101);
        to(883); chk("adj_min_02", digits, 16'h0201);
        to(885); chk("adj_min_wrap", digits, 16'h0001);
        to(887); chk("adj_min_again", digits, 16'h0101);
        sel = 1'b1;
        to(931); chk("adj_to_0123", digits, 16'h0123);
        adj = 1'b0;

        to(932); chk("still_paused", {15'h0000, running}, 16'h0000);
        to(933); chk("scan2_an", {12'h000, an}, 16'h000B);
                 chk("scan2_seg", {8'h00, seg}, 16'h0079);
        to(935); chk("scan3_an", {12'h000, an}, 16'h0007);
                 chk("scan3_seg", {8'h00, seg}, 16'h00C0);
        to(937); chk("scan0_an", {12'h000, an}, 16'h000E);
                 chk("scan0_seg", {8'h00, seg}, 16'h00B0);
        to(939); chk("scan1_an", {12'h000, an}, 16'h000D);
                 chk("scan1_seg", {8'h00, seg}, 16'h00A4);

        adj = 1'b1; sel = 1'b0;
        to(942); chk("blink0_idx2", {12'h000, an}, 16'h000B);
        to(943); chk("blink1_idx3", {12'h000, an}, 16'h000F);
        to(944); chk("blink1_idx3b", {12'h000, an}, 16'h000F);
        to(945); chk("blink1_idx0", {12'h000, an}, 16'h000E);
                 chk("blink1_seg0", {8'h00, seg}, 16'h00B0);
        to(947); chk("blink0_idx1", {12'h000, an}, 16'h000D);
        to(949); chk("blink1_idx2", {12'h000, an}, 16'h000F);
        sel = 1'b1;
        to(950); chk("blink_sel1_idx2", {12'h000, an}, 16'h000B);
        to(955); chk("blink_sel1_idx1", {12'h000, an}, 16'h000F);
        to(957); chk("blink_sel1_idx2b", {12'h000, an}, 16'h000B);
                 chk("sel_switch_digits", digits, 16'h0027);
        sel = 1'b0;
        to(959); chk("adj_min_to_01", digits, 16'h0127);
        sel = 1'b1;
        to(979); chk("adj_to_0137", digits, 16'h0137);
        adj = 1'b0;

        #2 rst = 1'b1;
        #1;
        chk("async_rst_digits",  digits, 16'h0000);
        chk("async_rst_an",      {12'h000, an}, 16'h000E);
        chk("async_rst_seg",     {8'h00, seg}, 16'h00C0);
        chk("async_rst_running", {15'h0000, running}, 16'h0001);
        #2 rst = 1'b0;
        cyc = 0;
        to(3); chk("post_rst_3", digits, 16'h0000);
        to(4); chk("post_rst_4", digits, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
